// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator display stage.
//   status encodings, 4-bit glyph codes and the 7-bit active-low segment type.
package calc_pkg;

  typedef logic [1:0] status_t;
  localparam status_t ST_ERRO    = 2'b00;
  localparam status_t ST_OCUPADO = 2'b01;
  localparam status_t ST_PRONTO  = 2'b10;
  localparam status_t ST_IMPRIME = 2'b11;

  // Glyph codes: 0..9 are the decimal digits, the rest are special glyphs.
  typedef logic [3:0] glyph_t;
  localparam glyph_t GLY_E     = 4'hA;
  localparam glyph_t GLY_R     = 4'hB;
  localparam glyph_t GLY_BLANK = 4'hF;

  // Segments {g,f,e,d,c,b,a}, active-low.
  typedef logic [6:0] seg_t;
  localparam seg_t SEG_BLANK = 7'h7F;

  // Non-BCD data from the core is kept as a blank digit.
  function automatic glyph_t to_glyph(input logic [3:0] d);
    return (d > 4'd9) ? GLY_BLANK : glyph_t'(d);
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational glyph code to active-low 7-segment pattern.
//   glyph : glyph code (0..9, GLY_E, GLY_R, anything else blank)
//   seg_c : segments {g,f,e,d,c,b,a}, active-low
module seg7_decoder
  import calc_pkg::*;
(
  input  glyph_t glyph,
  output seg_t   seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (glyph)
      4'd0:    seg_c = 7'h40;
      4'd1:    seg_c = 7'h79;
      4'd2:    seg_c = 7'h24;
      4'd3:    seg_c = 7'h30;
      4'd4:    seg_c = 7'h19;
      4'd5:    seg_c = 7'h12;
      4'd6:    seg_c = 7'h02;
      4'd7:    seg_c = 7'h78;
      4'd8:    seg_c = 7'h00;
      4'd9:    seg_c = 7'h10;
      GLY_E:   seg_c = 7'h06;
      GLY_R:   seg_c = 7'h2F;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/calc_display.sv
// Calculator display stage: assembles the core's printed digit stream into a
// shadow buffer, commits it atomically when printing ends, and scans the
// committed digits onto an 8-digit common-anode 7-segment display.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks digits above the most
// significant non-zero committed digit (digit 0 always shown).
//   clock, reset : clock, synchronous active-high reset
//   status       : core status (00 error, 01 busy, 10 ready, 11 printing)
//   data, pos    : BCD digit and print position (1..8 -> digit pos-1)
//   an           : digit enables, active-low
//   seg, dp      : segments {g,f,e,d,c,b,a} and decimal point, active-low
//   frame_done   : one-cycle pulse when the shadow buffer is committed
module calc_display
  import calc_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned N_DIGITS    = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          status,
  input  logic [3:0]          data,
  input  logic [3:0]          pos,
  output logic [N_DIGITS-1:0] an,
  output logic [6:0]          seg,
  output logic                dp,
  output logic                frame_done
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = $clog2(N_DIGITS);

  status_t       status_q;
  glyph_t        shadow    [N_DIGITS];
  glyph_t        committed [N_DIGITS];
  logic [CW-1:0] refresh_cnt;
  logic [IW-1:0] scan_idx;

  logic          pos_ok_c;
  logic [IW-1:0] wr_idx_c;
  logic          commit_c;
  glyph_t        glyph_c;
  logic          dp_c;
  seg_t          seg_c;

  assign pos_ok_c = (pos >= 4'd1) && (pos <= 4'(N_DIGITS));
  assign wr_idx_c = IW'(pos - 4'd1);
  // Printing just ended cleanly; error/busy after printing aborts the frame.
  assign commit_c = (status_q == ST_IMPRIME) && (status == ST_PRONTO);

  // Status history, digit buffers and commit pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      status_q   <= ST_PRONTO;
      frame_done <= 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
        shadow[i]    <= '0;
        committed[i] <= '0;
      end
    end else begin
      status_q   <= status;
      frame_done <= commit_c;
      if ((status == ST_IMPRIME) && pos_ok_c)
        shadow[wr_idx_c] <= to_glyph(data);
      if (commit_c)
        committed <= shadow;
    end
  end

  // Refresh divider and scan index.
  always_ff @(posedge clock) begin
    if (reset) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
    end else if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      scan_idx    <= (scan_idx == IW'(N_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [IW-1:0] msd_c;

  // Index of the most significant non-zero committed digit (0 if all zero).
  always_comb begin
    msd_c = '0;
    for (int i = 1; i < N_DIGITS; i++)
      if (committed[i] != 4'd0) msd_c = IW'(i);
  end
`endif

  // Mode mux: what the currently scanned digit should show.
  always_comb begin
    glyph_c = committed[scan_idx];
    dp_c    = 1'b1;
    case (status_q)
      ST_ERRO: begin
        if (scan_idx == IW'(2))      glyph_c = GLY_E;
        else if (scan_idx < IW'(2))  glyph_c = GLY_R;
        else                         glyph_c = GLY_BLANK;
      end
      ST_OCUPADO: dp_c = (scan_idx != '0);
      default: ;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    if ((status_q != ST_ERRO) && (scan_idx > msd_c))
      glyph_c = GLY_BLANK;
`endif
  end

  seg7_decoder u_dec (
    .glyph (glyph_c),
    .seg_c (seg_c)
  );

  // Registered display outputs; dark while in reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= ~(N_DIGITS'(1) << scan_idx);
      seg <= seg_c;
      dp  <= dp_c;
    end
  end

endmodule

// File: tb/tb_calc_display.sv
module tb_calc_display;

  localparam int unsigned DIV = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] status;
  logic [3:0] data;
  logic [3:0] pos;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;

  always #5 clock = ~clock;

  calc_display #(.REFRESH_DIV(DIV)) dut (
    .clock      (clock),
    .reset      (reset),
    .status     (status),
    .data       (data),
    .pos        (pos),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  int total = 0;
  int bad   = 0;
  int fd_cnt = 0;

  // Reference model: digit values as plain integers, scan position from the
  // number of clock edges since reset.
  int         m_sh [8];
  int         m_cm [8];
  logic [1:0] m_sq;
  int         m_n;
  bit         m_ok = 1'b0;
  logic [7:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;
  logic       e_fd;

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] render(input int d);
    int top;
    if (m_sq == 2'b00) return (d == 2) ? 7'h06 : (d < 2) ? 7'h2F : 7'h7F;
    top = 0;
    for (int i = 0; i < 8; i++) if (m_cm[i] != 0) top = i;
    if (LZ && d > top) return 7'h7F;
    return seg_of(m_cm[d]);
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin m_sh[i] = 0; m_cm[i] = 0; end
      m_sq = 2'b10; m_n = 0; m_ok = 1'b1;
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    end else if (m_ok) begin
      int sc;
      sc    = (m_n / DIV) % 8;
      e_an  = ~(8'h01 << sc);
      e_seg = render(sc);
      e_dp  = !(m_sq == 2'b01 && sc == 0);
      e_fd  = (m_sq == 2'b11 && status == 2'b10);
      if (e_fd) for (int i = 0; i < 8; i++) m_cm[i] = m_sh[i];
      if (status == 2'b11 && pos >= 1 && pos <= 8)
        m_sh[pos - 1] = (data > 9) ? 15 : int'(data);
      m_sq = status;
      m_n++;
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (m_ok) begin
      chk("an",  an, e_an);
      chk("seg", {1'b0, seg}, {1'b0, e_seg});
      chk("dp",  {7'b0, dp}, {7'b0, e_dp});
      chk("frame_done", {7'b0, frame_done}, {7'b0, e_fd});
    end
  end

  always @(negedge clock) if (frame_done === 1'b1) fd_cnt++;

  task automatic step();
    @(negedge clock);
  endtask

  // Wait (bounded) for digit idx to be lit, then check its glyph and dp.
  task automatic lit_digit(input string nm, input int idx, input logic [6:0] exp_seg,
                           input logic exp_dp);
    bit found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clock);
      if (an == ~(8'h01 << idx)) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL %s: digit %0d never enabled within 40 cycles", nm, idx);
    end else if (seg !== exp_seg || dp !== exp_dp) begin
      bad++;
      $display("FAIL %s: got seg=%h dp=%b want seg=%h dp=%b", nm, seg, dp, exp_seg, exp_dp);
    end
  endtask

  task automatic print_value(input int unsigned v);
    int unsigned t = v;
    status = 2'b11; pos = 4'd0; data = 4'($urandom_range(0, 15));
    step();
    for (int p = 1; p <= 8; p++) begin
      pos = 4'(p); data = 4'(t % 10); t = t / 10;
      step();
    end
    status = 2'b10; pos = 4'd0;
    step();
  endtask

  initial begin
    reset = 1'b1; status = 2'b10; pos = 4'd0; data = 4'd0;
    repeat (2) step();
    chk("rst_an_lit",  an, 8'hFF);
    chk("rst_seg_lit", {1'b0, seg}, 8'h7F);
    chk("rst_dp_lit",  {7'b0, dp}, 8'h01);
    reset = 1'b0;

    // Idle: all zeros, no commit.
    fd_cnt = 0;
    lit_digit("idle_d0", 0, 7'h40, 1'b1);
    lit_digit("idle_d7", 7, LZ ? 7'h7F : 7'h40, 1'b1);
    chk("idle_fd_cnt", 8'(fd_cnt), 8'd0);

    // Full frame 12345678.
    fd_cnt = 0;
    print_value(12345678);
    repeat (3) step();
    chk("print_fd_cnt", 8'(fd_cnt), 8'd1);
    lit_digit("print_d0", 0, 7'h00, 1'b1);
    lit_digit("print_d7", 7, 7'h79, 1'b1);

    // Aborted frame followed by error display.
    fd_cnt = 0;
    status = 2'b11; data = 4'd9;
    for (int p = 1; p <= 3; p++) begin pos = 4'(p); step(); end
    status = 2'b00; pos = 4'd0;
    repeat (3) step();
    lit_digit("err_d2", 2, 7'h06, 1'b1);
    lit_digit("err_d1", 1, 7'h2F, 1'b1);
    lit_digit("err_d0", 0, 7'h2F, 1'b1);
    lit_digit("err_d5", 5, 7'h7F, 1'b1);
    chk("abort_fd_cnt", 8'(fd_cnt), 8'd0);
    status = 2'b10;
    repeat (3) step();
    lit_digit("back_d0", 0, 7'h00, 1'b1);
    lit_digit("back_d2", 2, 7'h02, 1'b1);

    // Busy with 42 committed.
    print_value(42);
    status = 2'b01;
    repeat (3) step();
    lit_digit("busy_d0", 0, 7'h24, 1'b0);
    lit_digit("busy_d1", 1, 7'h19, 1'b1);
    lit_digit("busy_d2", 2, LZ ? 7'h7F : 7'h40, 1'b1);
    status = 2'b10;
    step();

    // Leading-zero handling: 305, then 0.
    print_value(305);
    repeat (3) step();
    lit_digit("v305_d2", 2, 7'h30, 1'b1);
    lit_digit("v305_d1", 1, 7'h40, 1'b1);
    lit_digit("v305_d0", 0, 7'h12, 1'b1);
    lit_digit("v305_d3", 3, LZ ? 7'h7F : 7'h40, 1'b1);
    print_value(0);
    repeat (3) step();
    lit_digit("v0_d0", 0, 7'h40, 1'b1);
    lit_digit("v0_d1", 1, LZ ? 7'h7F : 7'h40, 1'b1);

    // Randomized traffic, including occasional resets.
    for (int k = 0; k < 1500; k++) begin
      reset  = ($urandom_range(0, 99) == 0);
      status = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) :
               (($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11);
      pos    = 4'($urandom_range(0, 10));
      data   = 4'($urandom_range(0, 15));
      step();
    end
    reset = 1'b0; status = 2'b10;
    step();

    // Reset in the middle of a print.
    print_value(87654321);
    status = 2'b11; pos = 4'd4; data = 4'd7; reset = 1'b1;
    step();
    chk("midrst_an_lit",  an, 8'hFF);
    chk("midrst_seg_lit", {1'b0, seg}, 8'h7F);
    chk("midrst_fd_lit",  {7'b0, frame_done}, 8'h00);
    reset = 1'b0; status = 2'b10; pos = 4'd0;
    repeat (3) step();
    lit_digit("midrst_d0", 0, 7'h40, 1'b1);
    lit_digit("midrst_d3", 3, LZ ? 7'h7F : 7'h40, 1'b1);

    repeat (4) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
